// File: rtl/seg_bcd_counter_disp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_bcd_counter_disp : N-digit BCD up/down counter with a multiplexed      |
// | active-low 7-segment driver. Define SEG_LZB_EN for leading-zero blanking.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg_bcd_counter_disp #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 50_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap,
    output logic [DIGITS-1:0]     seg_sel,
    output logic [7:0]            seg_data
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int TDIV_W   = $clog2(TICK_DIV);
    localparam int SDIV_W   = $clog2(SCAN_DIV);
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TDIV_W-1:0] TICK_LAST = TDIV_W'(TICK_DIV - 1);
    localparam logic [SDIV_W-1:0] SCAN_LAST = SDIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [TDIV_W-1:0]   tick_div_q;
    logic [SDIV_W-1:0]   scan_div_q;
    logic [IDX_W-1:0]    idx_q;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic                wrap_q, wrap_d;
    logic [DIGITS-1:0]   seg_sel_q;
    logic [7:0]          seg_data_q;

    logic                tick;
    logic                scan_step;
    logic [4*DIGITS-1:0] up_val, dn_val, load_sat;
    logic                up_carry, dn_borrow;
    logic [DIGITS-1:0]   digit_blank;
    logic [3:0]          cur_digit;
    logic                cur_blank;

    assign tick      = (tick_div_q == TICK_LAST);
    assign scan_step = (scan_div_q == SCAN_LAST);

    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    // Ripple carry/borrow across digits; the final carry/borrow is the wrap.
    always_comb begin
        up_val    = count_q;
        dn_val    = count_q;
        load_sat  = load_val;
        up_carry  = 1'b1;
        dn_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (up_carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    up_val[4*i +: 4] = 4'd0;
                end else begin
                    up_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    up_carry         = 1'b0;
                end
            end
            if (dn_borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dn_val[4*i +: 4] = 4'd9;
                end else begin
                    dn_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    dn_borrow        = 1'b0;
                end
            end
            if (load_val[4*i +: 4] > 4'd9) begin
                load_sat[4*i +: 4] = 4'd9;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_sat;
        end else if (tick && run) begin
            if (up_dn) begin
                count_d = up_val;
                wrap_d  = up_carry;
            end else begin
                count_d = dn_val;
                wrap_d  = dn_borrow;
            end
        end
    end

`ifdef SEG_LZB_EN
    for (genvar k = 0; k < DIGITS; k++) begin : g_lzb
        if (k == 0) begin : g_lsd
            assign digit_blank[k] = 1'b0;
        end else begin : g_upper
            assign digit_blank[k] = (count_q[4*DIGITS-1:4*k] == '0);
        end
    end
`else
    assign digit_blank = '0;
`endif

    // Scan index 0 drives the most significant digit.
    always_comb begin
        cur_digit = '0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = count_q[4*(DIGITS-1-i) +: 4];
                cur_blank = digit_blank[DIGITS-1-i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_div_q <= '0;
            scan_div_q <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            seg_sel_q  <= '1;
            seg_data_q <= 8'hFF;
        end else begin
            tick_div_q <= tick ? '0 : tick_div_q + TDIV_W'(1);
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            if (scan_step) begin
                scan_div_q <= '0;
                idx_q      <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                seg_sel_q  <= ~(DIGITS'(1) << idx_q);
                seg_data_q <= cur_blank ? 8'hFF : seg_decode(cur_digit);
            end else begin
                scan_div_q <= scan_div_q + SDIV_W'(1);
            end
        end
    end

    assign count_bcd = count_q;
    assign wrap      = wrap_q;
    assign seg_sel   = seg_sel_q;
    assign seg_data  = seg_data_q;

endmodule
`default_nettype wire
